// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one instruction-memory read at a time, holds the
// fetched word for decode, and handles redirects, response draining and HALT.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  localparam logic [4:0]  OP_HALT = 5'b00000;
  localparam logic [15:0] NOP     = 16'h0800;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DRAIN, S_HOLD, S_HALT
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n, target;
  logic        load, clear, halt_set;

  assign target = redirect_pc & 16'hFFFE;

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    load     = 1'b0;
    clear    = 1'b0;
    halt_set = 1'b0;
    case (state)
      S_IDLE:  state_n = S_FETCH;
      S_FETCH: begin
        if (redirect) pc_n = target;
        state_n = redirect ? S_FETCH : S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          pc_n    = target;
          state_n = imem_rvalid ? S_FETCH : S_DRAIN;
        end else if (imem_rvalid) begin
          load    = 1'b1;
          pc_n    = pc + 16'd2;
          state_n = (imem_rdata[15:11] == OP_HALT) ? S_HALT : S_HOLD;
        end
      end
      S_DRAIN: begin
        // A redirect landing on the very cycle the stale response arrives still
        // retires that response; waiting for another would never end.
        if (redirect) pc_n = target;
        if (imem_rvalid) state_n = S_FETCH;
      end
      S_HOLD: begin
        if (redirect) pc_n = target;
        if (redirect || id_ready) begin
          clear   = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_HALT: begin
        if (!halted) begin
          if (redirect) begin
            pc_n    = target;
            clear   = 1'b1;
            state_n = S_FETCH;
          end else if (id_ready) begin
            clear    = 1'b1;
            halt_set = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= 16'h0000;
      if_valid    <= 1'b0;
      if_instr    <= NOP;
      if_pc       <= 16'h0000;
      if_pc_plus2 <= 16'h0000;
      halted      <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      // The request pulse is registered so it coincides exactly with the FETCH cycle.
      imem_req <= (state_n == S_FETCH);
      if (state_n == S_FETCH) imem_addr <= pc_n;
      if (load) begin
        if_valid    <= 1'b1;
        if_instr    <= imem_rdata;
        if_pc       <= pc;
        if_pc_plus2 <= pc + 16'd2;
      end
      if (clear)    if_valid <= 1'b0;
      if (halt_set) halted   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-configurable memory responder,
// a scoreboard of expected requests and accepted instructions, and scenario tasks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr, if_pc, if_pc_plus2;
  logic        id_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halted;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;
  bit pend = 0;
  int cnt = 0;
  logic [15:0] paddr = 16'h0000;

  logic [15:0] mem_over [logic [15:0]];
  logic [15:0] req_q [$];
  logic [47:0] acc_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_unit #(.RESET_PC(16'h0100)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus2(if_pc_plus2),
    .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mem_over.exists(a)) return mem_over[a];
    return {5'b00001, a[11:1]};
  endfunction

  // Memory: answers each request after 'lat' cycles with one rvalid pulse.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    forever begin
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pend = 0;
        end else cnt--;
      end
      if (imem_req === 1'b1) begin
        pend = 1; cnt = lat; paddr = imem_addr;
      end
    end
  end

  // Scoreboard: every request and every accepted instruction must match the queue head.
  initial begin
    logic [15:0] ea;
    logic [47:0] et;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (imem_req === 1'b1) begin
          checks++;
          if (req_q.size() == 0) begin
            errors++; $display("FAIL req_addr: unexpected request at %h, none expected", imem_addr);
          end else begin
            ea = req_q.pop_front();
            if (imem_addr !== ea) begin
              errors++; $display("FAIL req_addr: got %h expected %h", imem_addr, ea);
            end
          end
        end
        if (if_valid === 1'b1 && id_ready === 1'b1) begin
          checks++;
          if (acc_q.size() == 0) begin
            errors++; $display("FAIL accept: unexpected accept instr=%h pc=%h", if_instr, if_pc);
          end else begin
            et = acc_q.pop_front();
            if ({if_instr, if_pc, if_pc_plus2} !== et) begin
              errors++;
              $display("FAIL accept: got instr=%h pc=%h pc2=%h expected instr=%h pc=%h pc2=%h",
                       if_instr, if_pc, if_pc_plus2, et[47:32], et[31:16], et[15:0]);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(input int budget, output bit found);
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      if (imem_req === 1'b1) found = 1;
    end
  endtask

  task automatic pulse_redirect(input logic [15:0] a);
    redirect_pc = a;
    redirect = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; id_ready = 1'b0; lat = 1;
    req_q.delete(); acc_q.delete();
    repeat (2) @(negedge clk);
    pend = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr: got %h expected 0000", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", if_valid); end
    checks++; if (if_instr !== 16'h0800) begin errors++; $display("FAIL rst_instr: got %h expected 0800", if_instr); end
    checks++; if (if_pc !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h expected 0000", if_pc); end
    checks++; if (if_pc_plus2 !== 16'h0000) begin errors++; $display("FAIL rst_pc2: got %h expected 0000", if_pc_plus2); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
  endtask

  task automatic test_sequence();
    bit found;
    int prev;
    do_reset();
    req_q = '{16'h0100, 16'h0102, 16'h0104};
    acc_q.push_back({mem_word(16'h0100), 16'h0100, 16'h0102});
    acc_q.push_back({mem_word(16'h0102), 16'h0102, 16'h0104});
    id_ready = 1'b1;
    rst_n = 1'b1;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_req(20, found);
      checks++; if (!found) begin errors++; $display("FAIL seq_req%0d: no request within 20 cycles", k); end
      if (k > 0) begin
        checks++;
        if (cyc - prev != 3) begin errors++; $display("FAIL seq_spacing%0d: got %0d cycles expected 3", k, cyc - prev); end
      end
      prev = cyc;
    end
    id_ready = 1'b0;
    repeat (3) tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0104 || if_pc_plus2 !== 16'h0106) begin
      errors++; $display("FAIL seq_hold: got valid=%b pc=%h pc2=%h expected 1 0104 0106", if_valid, if_pc, if_pc_plus2); end
    checks++; if (req_q.size() != 0 || acc_q.size() != 0) begin
      errors++; $display("FAIL seq_queues: got req=%0d acc=%0d pending expected 0 0", req_q.size(), acc_q.size()); end
  endtask

  task automatic test_stall();
    bit found;
    do_reset();
    mem_over[16'h0010] = 16'h4123;
    req_q = '{16'h0100, 16'h0010};
    rst_n = 1'b1;
    wait_req(20, found);
    checks++; if (!found) begin errors++; $display("FAIL stall_first: no request within 20 cycles"); end
    repeat (2) tick();
    pulse_redirect(16'h0010);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
      errors++; $display("FAIL stall_redir: got req=%b addr=%h expected 1 0010", imem_req, imem_addr); end
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (if_valid !== 1'b1 || if_instr !== 16'h4123 || imem_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: got valid=%b instr=%h req=%b expected 1 4123 0", i, if_valid, if_instr, imem_req); end
      tick();
    end
    acc_q.push_back({16'h4123, 16'h0010, 16'h0012});
    req_q.push_back(16'h0012);
    id_ready = 1'b1;
    wait_req(10, found);
    id_ready = 1'b0;
    checks++; if (!found) begin errors++; $display("FAIL stall_resume: no request within 10 cycles"); end
    tick();
    checks++; if (req_q.size() != 0 || acc_q.size() != 0) begin
      errors++; $display("FAIL stall_queues: got req=%0d acc=%0d pending expected 0 0", req_q.size(), acc_q.size()); end
    mem_over.delete();
  endtask

  task automatic test_drain();
    bit found;
    do_reset();
    lat = 3;
    req_q = '{16'h0100, 16'h0040};
    rst_n = 1'b1;
    wait_req(20, found);
    checks++; if (!found) begin errors++; $display("FAIL drain_first: no request within 20 cycles"); end
    tick();
    pulse_redirect(16'h0041);
    for (int i = 0; i < 2; i++) begin
      checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
        errors++; $display("FAIL drain_wait%0d: got valid=%b req=%b expected 0 0", i, if_valid, imem_req); end
      tick();
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || if_valid !== 1'b0) begin
      errors++; $display("FAIL drain_refetch: got req=%b addr=%h valid=%b expected 1 0040 0", imem_req, imem_addr, if_valid); end
    repeat (4) tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0040 || if_instr !== mem_word(16'h0040)) begin
      errors++; $display("FAIL drain_data: got valid=%b pc=%h instr=%h expected 1 0040 %h", if_valid, if_pc, if_instr, mem_word(16'h0040)); end
    checks++; if (req_q.size() != 0) begin errors++; $display("FAIL drain_queues: got %0d pending expected 0", req_q.size()); end
    lat = 1;
  endtask

  task automatic test_halt();
    bit found;
    do_reset();
    mem_over[16'h0020] = 16'h0000;
    req_q = '{16'h0100, 16'h0020};
    rst_n = 1'b1;
    wait_req(20, found);
    checks++; if (!found) begin errors++; $display("FAIL halt_first: no request within 20 cycles"); end
    repeat (2) tick();
    pulse_redirect(16'h0020);
    repeat (2) tick();
    checks++; if (if_valid !== 1'b1 || if_instr !== 16'h0000 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_pending: got valid=%b instr=%h halted=%b expected 1 0000 0", if_valid, if_instr, halted); end
    acc_q.push_back({16'h0000, 16'h0020, 16'h0022});
    id_ready = 1'b1;
    tick();
    checks++; if (halted !== 1'b1 || if_valid !== 1'b0) begin
      errors++; $display("FAIL halt_taken: got halted=%b valid=%b expected 1 0", halted, if_valid); end
    for (int i = 0; i < 20; i++) begin
      redirect_pc = 16'h0300;
      redirect = (i % 5 == 0);
      tick();
      checks++; if (imem_req !== 1'b0 || halted !== 1'b1) begin
        errors++; $display("FAIL halt_quiet%0d: got req=%b halted=%b expected 0 1", i, imem_req, halted); end
    end
    redirect = 1'b0; id_ready = 1'b0;
    checks++; if (acc_q.size() != 0 || req_q.size() != 0) begin
      errors++; $display("FAIL halt_queues: got req=%0d acc=%0d pending expected 0 0", req_q.size(), acc_q.size()); end
    mem_over.delete();
  endtask

  task automatic test_halt_cancel();
    bit found;
    do_reset();
    mem_over[16'h0030] = 16'h0000;
    req_q = '{16'h0100, 16'h0030, 16'h0200};
    rst_n = 1'b1;
    wait_req(20, found);
    checks++; if (!found) begin errors++; $display("FAIL cancel_first: no request within 20 cycles"); end
    repeat (2) tick();
    pulse_redirect(16'h0030);
    repeat (2) tick();
    checks++; if (if_valid !== 1'b1 || if_instr !== 16'h0000) begin
      errors++; $display("FAIL cancel_pending: got valid=%b instr=%h expected 1 0000", if_valid, if_instr); end
    pulse_redirect(16'h0200);
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0200 || if_valid !== 1'b0) begin
      errors++; $display("FAIL cancel_redir: got halted=%b req=%b addr=%h valid=%b expected 0 1 0200 0", halted, imem_req, imem_addr, if_valid); end
    repeat (2) tick();
    checks++; if (halted !== 1'b0 || if_valid !== 1'b1 || if_pc !== 16'h0200) begin
      errors++; $display("FAIL cancel_next: got halted=%b valid=%b pc=%h expected 0 1 0200", halted, if_valid, if_pc); end
    mem_over.delete();
  endtask

  task automatic test_wrap_and_reset();
    bit found;
    do_reset();
    req_q = '{16'h0100, 16'hFFFE, 16'h0000};
    rst_n = 1'b1;
    wait_req(20, found);
    checks++; if (!found) begin errors++; $display("FAIL wrap_first: no request within 20 cycles"); end
    repeat (2) tick();
    pulse_redirect(16'hFFFF);
    checks++; if (imem_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_addr: got %h expected fffe", imem_addr); end
    repeat (2) tick();
    checks++; if (if_pc !== 16'hFFFE || if_pc_plus2 !== 16'h0000) begin
      errors++; $display("FAIL wrap_pc2: got pc=%h pc2=%h expected fffe 0000", if_pc, if_pc_plus2); end
    lat = 3;
    acc_q.push_back({mem_word(16'hFFFE), 16'hFFFE, 16'h0000});
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++; $display("FAIL wrap_next: got req=%b addr=%h expected 1 0000", imem_req, imem_addr); end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || if_valid !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL arst_ctl: got req=%b addr=%h valid=%b halted=%b expected 0 0000 0 0", imem_req, imem_addr, if_valid, halted); end
    checks++; if (if_instr !== 16'h0800 || if_pc !== 16'h0000 || if_pc_plus2 !== 16'h0000) begin
      errors++; $display("FAIL arst_data: got instr=%h pc=%h pc2=%h expected 0800 0000 0000", if_instr, if_pc, if_pc_plus2); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_q.push_back(16'h0100);
    wait_req(10, found);
    checks++; if (!found || if_valid !== 1'b0) begin
      errors++; $display("FAIL stale_refetch: got found=%b valid=%b expected 1 0", found, if_valid); end
    repeat (4) tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0100 || if_instr !== mem_word(16'h0100)) begin
      errors++; $display("FAIL stale_data: got valid=%b pc=%h instr=%h expected 1 0100 %h", if_valid, if_pc, if_instr, mem_word(16'h0100)); end
    checks++; if (req_q.size() != 0 || acc_q.size() != 0) begin
      errors++; $display("FAIL wrap_queues: got req=%0d acc=%0d pending expected 0 0", req_q.size(), acc_q.size()); end
    lat = 1;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_drain();
    test_halt();
    test_halt_cancel();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
